kara_pp_seq_42bit: RTL and testbench

Sequential partial-product stage for the 42-bit GF(2)[x] Karatsuba multiplier. It accepts two 42-bit polynomial operands and produces the three 41-bit Karatsuba partial products: low, middle (already corrected), and high. These feed `B2_in1`/`B2_in2`/`B2_in3` of the 41-bit overlap stage directly. A single bit-serial 21×21 carry-less multiplier is time-shared across the three products, trading latency for area.

---
 rtl/kara_pp_seq_42bit_pkg.sv | 20 ++
 rtl/kara_pp_seq_42bit_gf2_mul.sv | 56 +++++
 rtl/kara_pp_seq_42bit.sv | 158 +++++++++++++++
 tb/tb_kara_pp_seq_42bit.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/kara_pp_seq_42bit_pkg.sv
// Shared constants and FSM state type for the 42-bit Karatsuba partial-product stage.
// Operands split into 21-bit halves; every carry-less half product is 41 bits wide.
package kara_pkg;

  localparam int N_W    = 42;
  localparam int HALF_W = 21;
  localparam int PP_W   = 41;

  // Index of the last serial step in one half product (counter runs 0..20).
  localparam logic [4:0] LAST_STEP = 5'd20;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MUL_LO  = 3'd1,
    MUL_HI  = 3'd2,
    MUL_MID = 3'd3,
    DONE    = 3'd4
  } kara_pp_state_t;

endpackage

// File: rtl/kara_pp_seq_42bit_gf2_mul.sv
// Bit-serial 21x21 carry-less multiplier, Horner MSB-first, one multiplier bit per clock.
// p presents the value after the current step, so it holds the full product in the cycle done is high.
module gf2_mul_serial_21bit
  import kara_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [HALF_W-1:0] a,
  input  logic [HALF_W-1:0] b,
  output logic              done,
  output logic [PP_W-1:0]   p
);

  logic [HALF_W-1:0] a_r;
  logic [HALF_W-1:0] b_r;
  logic [PP_W-1:0]   acc_r;
  logic [4:0]        cnt_r;
  logic              run_r;
  logic [PP_W-1:0]   step_s;

  // b_r shifts left, so its MSB is always the next multiplier bit to consume.
  assign step_s = (acc_r << 1) ^
                  (b_r[HALF_W-1] ? {{(PP_W-HALF_W){1'b0}}, a_r} : {PP_W{1'b0}});
  assign done   = run_r && (cnt_r == LAST_STEP);
  assign p      = step_s;

  // Operand capture, accumulator and step counter; load restarts even on the finishing step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r   <= {HALF_W{1'b0}};
      b_r   <= {HALF_W{1'b0}};
      acc_r <= {PP_W{1'b0}};
      cnt_r <= 5'd0;
      run_r <= 1'b0;
    end else if (load) begin
      a_r   <= a;
      b_r   <= b;
      acc_r <= {PP_W{1'b0}};
      cnt_r <= 5'd0;
      run_r <= 1'b1;
    end else if (run_r) begin
      acc_r <= step_s;
      b_r   <= b_r << 1;
      if (done) begin
        cnt_r <= 5'd0;
        run_r <= 1'b0;
      end else begin
        cnt_r <= cnt_r + 5'd1;
      end
    end else begin
      acc_r <= acc_r;
    end
  end

endmodule

// File: rtl/kara_pp_seq_42bit.sv
// Sequential Karatsuba partial-product stage: one serial multiplier time-shared for the
// low, high and middle products; the middle term leaves already corrected by pp_lo ^ pp_hi.
module kara_pp_seq_42bit
  import kara_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N_W-1:0]  a,
  input  logic [N_W-1:0]  b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PP_W-1:0] pp_lo,
  output logic [PP_W-1:0] pp_mid,
  output logic [PP_W-1:0] pp_hi
);

  kara_pp_state_t    state_r;
  kara_pp_state_t    state_s;
  logic [N_W-1:0]    a_r;
  logic [N_W-1:0]    b_r;
  logic [PP_W-1:0]   pp_lo_r;
  logic [PP_W-1:0]   pp_mid_r;
  logic [PP_W-1:0]   pp_hi_r;
  logic              out_valid_r;
  logic              mul_load_s;
  logic [HALF_W-1:0] mul_a_s;
  logic [HALF_W-1:0] mul_b_s;
  logic              mul_done_s;
  logic [PP_W-1:0]   mul_p_s;

  gf2_mul_serial_21bit u_mul (
    .clk  (clk),
    .rst  (rst),
    .load (mul_load_s),
    .a    (mul_a_s),
    .b    (mul_b_s),
    .done (mul_done_s),
    .p    (mul_p_s)
  );

  assign in_ready  = (state_r == IDLE) && !rst;
  assign out_valid = out_valid_r;
  assign pp_lo     = pp_lo_r;
  assign pp_mid    = pp_mid_r;
  assign pp_hi     = pp_hi_r;

  // Next state and multiplier load; each finishing step immediately loads the next half pair.
  always_comb begin
    state_s    = state_r;
    mul_load_s = 1'b0;
    mul_a_s    = a[HALF_W-1:0];
    mul_b_s    = b[HALF_W-1:0];
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          mul_load_s = 1'b1;
          state_s    = MUL_LO;
        end else begin
          state_s = IDLE;
        end
      end
      MUL_LO: begin
        mul_a_s = a_r[N_W-1:HALF_W];
        mul_b_s = b_r[N_W-1:HALF_W];
        if (mul_done_s) begin
          mul_load_s = 1'b1;
          state_s    = MUL_HI;
        end else begin
          state_s = MUL_LO;
        end
      end
      MUL_HI: begin
        mul_a_s = a_r[HALF_W-1:0] ^ a_r[N_W-1:HALF_W];
        mul_b_s = b_r[HALF_W-1:0] ^ b_r[N_W-1:HALF_W];
        if (mul_done_s) begin
          mul_load_s = 1'b1;
          state_s    = MUL_MID;
        end else begin
          state_s = MUL_HI;
        end
      end
      MUL_MID: begin
        if (mul_done_s) begin
          state_s = DONE;
        end else begin
          state_s = MUL_MID;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand latch, result registers and output handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r         <= {N_W{1'b0}};
      b_r         <= {N_W{1'b0}};
      pp_lo_r     <= {PP_W{1'b0}};
      pp_mid_r    <= {PP_W{1'b0}};
      pp_hi_r     <= {PP_W{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r <= a;
            b_r <= b;
          end
        end
        MUL_LO: begin
          if (mul_done_s) begin
            pp_lo_r <= mul_p_s;
          end
        end
        MUL_HI: begin
          if (mul_done_s) begin
            pp_hi_r <= mul_p_s;
          end
        end
        MUL_MID: begin
          if (mul_done_s) begin
            pp_mid_r    <= mul_p_s ^ pp_lo_r ^ pp_hi_r;
            out_valid_r <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kara_pp_seq_42bit.sv
// Self-checking bench for kara_pp_seq_42bit: scoreboard of expected partial products,
// directed vectors, random vectors against a carry-less model, backpressure and mid-run reset.
module tb_kara_pp_seq_42bit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [41:0] a;
  logic [41:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [40:0] pp_lo;
  logic [40:0] pp_mid;
  logic [40:0] pp_hi;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [41:0] a;
    logic [41:0] b;
    logic [40:0] lo;
    logic [40:0] mid;
    logic [40:0] hi;
  } exp_t;

  exp_t sb[$];

  kara_pp_seq_42bit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pp_lo     (pp_lo),
    .pp_mid    (pp_mid),
    .pp_hi     (pp_hi)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [40:0] clmul21(input logic [20:0] x, input logic [20:0] y);
    logic [40:0] r;
    r = '0;
    for (int i = 0; i < 21; i++) begin
      if (y[i]) r = r ^ (41'(x) << i);
    end
    return r;
  endfunction

  function automatic logic [82:0] clmul42(input logic [41:0] x, input logic [41:0] y);
    logic [82:0] r;
    r = '0;
    for (int i = 0; i < 42; i++) begin
      if (y[i]) r = r ^ (83'(x) << i);
    end
    return r;
  endfunction

  function automatic exp_t model(input logic [41:0] x, input logic [41:0] y);
    exp_t e;
    e.a   = x;
    e.b   = y;
    e.lo  = clmul21(x[20:0], y[20:0]);
    e.hi  = clmul21(x[41:21], y[41:21]);
    e.mid = clmul21(x[20:0] ^ x[41:21], y[20:0] ^ y[41:21]) ^ e.lo ^ e.hi;
    return e;
  endfunction

  // Waits (bounded) for in_ready, presents one operand pair, pushes its expectation.
  task automatic send_op(input exp_t e, output int acc_cyc);
    int guard;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) begin
      errors++; checks++;
      $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
    end
    a = e.a; b = e.b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    acc_cyc = cyc;
    sb.push_back(e);
  endtask

  // Counts cycles from the acceptance edge until out_valid, bounded.
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %0b want 0", in_ready); end
    checks++; if ({pp_lo, pp_mid, pp_hi} !== 123'd0) begin
      errors++; $display("FAIL rst_pp: got %h %h %h want 0", pp_lo, pp_mid, pp_hi);
    end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_in_ready: got %0b want 1", in_ready); end
  endtask

  task automatic test_directed();
    logic [41:0] ta [3];
    logic [41:0] tb_ [3];
    logic [40:0] tl [3];
    logic [40:0] tm [3];
    logic [40:0] th [3];
    exp_t e;
    exp_t got;
    int lat;
    int acc;
    ta[0] = 42'd1;                  tb_[0] = 42'd1;
    tl[0] = 41'd1;                  tm[0] = 41'd0; th[0] = 41'd0;
    ta[1] = 42'd1 << 21;            tb_[1] = 42'd1;
    tl[1] = 41'd0;                  tm[1] = 41'd1; th[1] = 41'd0;
    ta[2] = 42'h3FF_FFFF_FFFF;      tb_[2] = 42'h3FF_FFFF_FFFF;
    tl[2] = 41'h155_5555_5555;      tm[2] = 41'd0; th[2] = 41'h155_5555_5555;
    for (int i = 0; i < 3; i++) begin
      e.a = ta[i]; e.b = tb_[i]; e.lo = tl[i]; e.mid = tm[i]; e.hi = th[i];
      send_op(e, acc);
      wait_out(lat);
      checks++; if (lat !== 63) begin errors++; $display("FAIL dir%0d_latency: got %0d want 63", i, lat); end
      got = sb.pop_front();
      checks++; if (pp_lo !== got.lo) begin errors++; $display("FAIL dir%0d_pp_lo: got %h want %h", i, pp_lo, got.lo); end
      checks++; if (pp_mid !== got.mid) begin errors++; $display("FAIL dir%0d_pp_mid: got %h want %h", i, pp_mid, got.mid); end
      checks++; if (pp_hi !== got.hi) begin errors++; $display("FAIL dir%0d_pp_hi: got %h want %h", i, pp_hi, got.hi); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++; $display("FAIL dir%0d_handshake: out_valid=%0b in_ready=%0b want 0 1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_random(input int count);
    exp_t e;
    exp_t got;
    int lat;
    int acc;
    logic [82:0] full;
    for (int i = 0; i < count; i++) begin
      e = model(42'({$urandom(), $urandom()}), 42'({$urandom(), $urandom()}));
      send_op(e, acc);
      wait_out(lat);
      got = sb.pop_front();
      checks++; if (lat !== 63 || pp_lo !== got.lo || pp_mid !== got.mid || pp_hi !== got.hi) begin
        errors++;
        $display("FAIL rnd%0d: lat=%0d pp=%h %h %h want lat=63 pp=%h %h %h",
                 i, lat, pp_lo, pp_mid, pp_hi, got.lo, got.mid, got.hi);
      end
      full = 83'(pp_lo) ^ (83'(pp_mid) << 21) ^ (83'(pp_hi) << 42);
      checks++; if (full !== clmul42(got.a, got.b)) begin
        errors++; $display("FAIL rnd%0d_overlap: got %h want %h", i, full, clmul42(got.a, got.b));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    exp_t got;
    int lat;
    int acc;
    logic [122:0] held;
    out_ready = 1'b0;
    e = model(42'h2AB_CDEF_0123, 42'h155_4321_FEDC);
    send_op(e, acc);
    wait_out(lat);
    got = sb.pop_front();
    checks++; if (lat !== 63 || {pp_lo, pp_mid, pp_hi} !== {got.lo, got.mid, got.hi}) begin
      errors++; $display("FAIL bp_result: lat=%0d pp=%h %h %h want 63 %h %h %h",
                         lat, pp_lo, pp_mid, pp_hi, got.lo, got.mid, got.hi);
    end
    held = {pp_lo, pp_mid, pp_hi};
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        a = 42'h0F0_F0F0_F0F0; b = 42'h123_4567_89AB; in_valid = 1'b1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || {pp_lo, pp_mid, pp_hi} !== held) begin
        errors++; $display("FAIL bp_hold%0d: out_valid=%0b in_ready=%0b pp=%h want 1 0 %h",
                           i, out_valid, in_ready, {pp_lo, pp_mid, pp_hi}, held);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: out_valid=%0b in_ready=%0b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    exp_t got;
    int lat;
    int acc;
    out_ready = 1'b1;
    e = model(42'h3A5_5A5A_1234, 42'h1C3_3C3C_0F0F);
    send_op(e, acc);
    repeat (30) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || {pp_lo, pp_mid, pp_hi} !== 123'd0) begin
      errors++; $display("FAIL mid_rst: out_valid=%0b in_ready=%0b pp=%h %h %h want 0 0 0",
                         out_valid, in_ready, pp_lo, pp_mid, pp_hi);
    end
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_in_ready: got %0b want 1", in_ready); end
    e = model(42'h2DE_ADBE_EF01, 42'h0BE_EFCA_FE55);
    send_op(e, acc);
    wait_out(lat);
    got = sb.pop_front();
    checks++; if (lat !== 63 || {pp_lo, pp_mid, pp_hi} !== {got.lo, got.mid, got.hi}) begin
      errors++; $display("FAIL mid_rst_rerun: lat=%0d pp=%h %h %h want 63 %h %h %h",
                         lat, pp_lo, pp_mid, pp_hi, got.lo, got.mid, got.hi);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    exp_t got;
    int lat;
    int acc0;
    int acc1;
    out_ready = 1'b1;
    e = model(42'h111_2222_3333, 42'h044_5555_6666);
    send_op(e, acc0);
    wait_out(lat);
    got = sb.pop_front();
    checks++; if ({pp_lo, pp_mid, pp_hi} !== {got.lo, got.mid, got.hi}) begin
      errors++; $display("FAIL b2b_first: pp=%h %h %h want %h %h %h", pp_lo, pp_mid, pp_hi, got.lo, got.mid, got.hi);
    end
    e = model(42'h3FF_0000_FFFF, 42'h200_0001_8001);
    send_op(e, acc1);
    checks++; if (acc1 - acc0 !== 65) begin
      errors++; $display("FAIL b2b_throughput: got %0d cycles want 65", acc1 - acc0);
    end
    wait_out(lat);
    got = sb.pop_front();
    checks++; if (lat !== 63 || {pp_lo, pp_mid, pp_hi} !== {got.lo, got.mid, got.hi}) begin
      errors++; $display("FAIL b2b_second: lat=%0d pp=%h %h %h want 63 %h %h %h",
                         lat, pp_lo, pp_mid, pp_hi, got.lo, got.mid, got.hi);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    test_random(1000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
